// File: rtl/multicycle_sequencer.sv
`timescale 1ns/1ps
// Multi-cycle control sequencer for the RV64 datapath.
// Steps instructions through fetch/decode/exec/mem/wb and owns the memory handshake.
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             take_branch,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_is_data,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_load,
  output logic             pc_sel,
  output logic             reg_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             trapped,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam bit          TO_EN   = TIMEOUT != 0;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t           st;
  state_t           nxt_instr;
  logic [31:0]      wait_cnt;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] ret_q;

  logic is_load;
  logic is_store;
  logic is_branch;
  logic is_system;
  logic is_legal;
  logic timed_out;

  assign is_load   = opcode == OP_LOAD;
  assign is_store  = opcode == OP_STORE;
  assign is_branch = opcode == OP_BRANCH;
  assign is_system = opcode == OP_SYSTEM;

  always_comb begin
    is_legal = 1'b0;
    unique case (1'b1)
      opcode == OP_LOAD,
      opcode == OP_STORE,
      opcode == OP_OP,
      opcode == OP_IMM,
      opcode == OP_OP32,
      opcode == OP_IMM32,
      opcode == OP_BRANCH,
      opcode == OP_JAL,
      opcode == OP_JALR,
      opcode == OP_LUI,
      opcode == OP_AUIPC: is_legal = 1'b1;
      default:            is_legal = 1'b0;
    endcase
  end

  // A ready arriving on the threshold cycle still completes normally.
  assign timed_out = TO_EN && mem_req && !mem_ready
                  && (wait_cnt == TO_LAST);

  assign nxt_instr = run ? S_FETCH : S_IDLE;

  always_comb begin
    mem_req     = 1'b0;
    mem_is_data = 1'b0;
    mem_we      = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    reg_we      = 1'b0;
    unique case (st)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
      end
      S_EXEC: begin
        pc_load = is_branch;
      end
      S_MEM: begin
        mem_req     = 1'b1;
        mem_is_data = 1'b1;
        mem_we      = is_store;
        pc_load     = is_store & mem_ready;
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_load = 1'b1;
      end
      default: begin
      end
    endcase
    pc_sel = pc_load & take_branch;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= S_IDLE;
      wait_cnt <= '0;
      cause_q  <= '0;
      ret_q    <= '0;
    end else begin
      if (mem_req && !mem_ready)
        wait_cnt <= wait_cnt + 32'd1;
      else
        wait_cnt <= '0;

      if (pc_load)
        ret_q <= ret_q + CNT_W'(1);

      unique case (st)
        S_IDLE: begin
          if (run)
            st <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            st <= S_DECODE;
          end else if (timed_out) begin
            st      <= S_TRAP;
            cause_q <= 2'd2;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            st <= S_EXEC;
          end else if (is_system) begin
            st <= S_HALT;
          end else begin
            st      <= S_TRAP;
            cause_q <= 2'd1;
          end
        end
        S_EXEC: begin
          if (is_branch)
            st <= nxt_instr;
          else if (is_load || is_store)
            st <= S_MEM;
          else
            st <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            st <= is_store ? nxt_instr : S_WB;
          end else if (timed_out) begin
            st      <= S_TRAP;
            cause_q <= 2'd3;
          end
        end
        S_WB: begin
          st <= nxt_instr;
        end
        default: begin
        end
      endcase
    end
  end

  assign state      = st;
  assign halted     = st == S_HALT;
  assign trapped    = st == S_TRAP;
  assign trap_cause = cause_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for multicycle_sequencer.
// An instruction-level model predicts outcome, latency and counts.
module tb_multicycle_sequencer;

  localparam int TO = 4;
  localparam int CW = 8;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] SYS = 7'b1110011;

  logic [6:0] legal [11] = '{7'b0000011, 7'b0100011, 7'b0110011,
                             7'b0010011, 7'b0111011, 7'b0011011,
                             7'b1100011, 7'b1101111, 7'b1100111,
                             7'b0110111, 7'b0010111};
  logic [6:0] ill [4] = '{7'b0000000, 7'b1111111,
                          7'b0001111, 7'b1010011};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic [6:0]    opcode = '0;
  logic          take_branch = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_is_data, mem_we, ir_load;
  logic          pc_load, pc_sel, reg_we, halted, trapped;
  logic [2:0]    state;
  logic [1:0]    trap_cause;
  logic [CW-1:0] retired;

  multicycle_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .take_branch(take_branch), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_is_data(mem_is_data), .mem_we(mem_we),
    .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel),
    .reg_we(reg_we), .state(state), .halted(halted),
    .trapped(trapped), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  // kind: 0 retire, 1 trap, 2 halt
  typedef struct {
    int            kind;
    logic [1:0]    cause;
    logic          psel;
    int            lat;
    int            regwe;
    int            memwe;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_ret = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [6:0] op, input int wf,
                                 input int wd, input logic tb,
                                 input logic [CW-1:0] cur);
    exp_t e;
    bit mem_op, br, ok;
    e.kind = 0; e.cause = 0; e.psel = tb; e.lat = 0;
    e.regwe = 0; e.memwe = 0; e.ret = cur;
    mem_op = (op == LD) || (op == ST);
    br = op == BR;
    ok = 0;
    foreach (legal[i]) if (legal[i] == op) ok = 1;
    if (wf >= TO) begin
      e.kind = 1; e.cause = 2; e.lat = TO + 1;
    end else if (op == SYS) begin
      e.kind = 2; e.lat = wf + 3;
    end else if (!ok) begin
      e.kind = 1; e.cause = 1; e.lat = wf + 3;
    end else if (mem_op && wd >= TO) begin
      e.kind = 1; e.cause = 3; e.lat = wf + TO + 4;
    end else begin
      e.lat = wf + (br ? 3 : (op == LD ? 5 : 4)) + (mem_op ? wd : 0);
      e.regwe = (br || op == ST) ? 0 : 1;
      e.memwe = (op == ST) ? wd + 1 : 0;
      e.ret = cur + 1'b1;
    end
    return e;
  endfunction

  // Monitor: pops on every instruction end, trap entry or halt entry.
  initial begin
    int cyc, rw, mw, il;
    bit pf, pt, ph, rp;
    logic [CW-1:0] pr;
    exp_t e;
    cyc = 0; rw = 0; mw = 0; il = 0;
    pf = 0; pt = 0; ph = 0; rp = 0; pr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pf = 0; pt = 0; ph = 0; rp = 0; cyc = 0;
      end else begin
        if (rp) begin
          chk("retired", retired, pr);
          rp = 0;
        end
        if (mem_req && !mem_is_data && !pf) begin
          cyc = 1; rw = 0; mw = 0; il = 0;
        end else begin
          cyc++;
        end
        pf = mem_req && !mem_is_data;
        if (reg_we) rw++;
        if (mem_we) mw++;
        if (ir_load) il++;
        if (!pc_load) chk("pc_sel_idle", pc_sel, 0);
        if (mem_we) chk("mem_we_data", mem_is_data, 1);
        if (pc_load || (trapped && !pt) || (halted && !ph)) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty actual=event required=none state=%0d",
                     state);
          end else begin
            e = sb.pop_front();
            chk("kind", pc_load ? 0 : (trapped ? 1 : 2), e.kind);
            chk("latency", cyc, e.lat);
            if (e.kind == 0) begin
              chk("pc_sel", pc_sel, e.psel);
              chk("reg_we_cnt", rw, e.regwe);
              chk("mem_we_cnt", mw, e.memwe);
              chk("ir_load_cnt", il, 1);
              rp = 1; pr = e.ret;
            end else if (e.kind == 1) begin
              chk("trap_cause", trap_cause, e.cause);
            end
          end
        end
        if (trapped || halted)
          chk("quiet", {mem_req, mem_we, ir_load, pc_load, reg_we}, 0);
        pt = trapped; ph = halted;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n;
    n = 0;
    while (state !== s && n < 40) begin tick(); n++; end
    chk(nm, state, s);
  endtask

  task automatic wait_mem();
    int n;
    n = 0;
    while (!(mem_req && mem_is_data) && n < 20) begin tick(); n++; end
    chk("mem_entry", {mem_req, mem_is_data}, 2'b11);
  endtask

  // Hold ready low for w request cycles of the current transfer.
  task automatic serve(input int w);
    int i;
    logic d;
    i = 0;
    d = mem_is_data;
    while (mem_req && mem_is_data == d && i < 60) begin
      mem_ready = (i >= w);
      tick();
      i++;
    end
    mem_ready = 1'b0;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (!(state inside {3'd0, 3'd1, 3'd6, 3'd7}) && n < 40) begin
      tick(); n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    exp_ret = '0;
    run = 1'b1;
    mem_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] op, input int wf, input int wd,
                           input logic tb, input logic nrun, input int hold);
    exp_t e;
    logic [2:0] es;
    wait_state(3'd1, "fetch_start");
    e = model(op, wf, wd, tb, exp_ret);
    sb.push_back(e);
    if (e.kind == 0) exp_ret = e.ret;
    opcode = op;
    take_branch = tb;
    run = nrun;
    serve(wf);
    if (wf < TO) chk("decode_entry", state, 2);
    if ((op == LD || op == ST) && wf < TO && e.kind != 2) begin
      wait_mem();
      serve(wd);
    end
    settle();
    es = (e.kind == 1) ? 3'd7 : (e.kind == 2) ? 3'd6 : (nrun ? 3'd1 : 3'd0);
    chk("end_state", state, es);
    if (e.kind != 0) begin
      run = 1'b1;
      repeat (hold) tick();
      chk("absorb", state, es);
      do_reset();
    end else if (!nrun) begin
      repeat (hold) tick();
      chk("idle_hold", state, 0);
      run = 1'b1;
    end
  endtask

  initial begin
    logic [6:0] op;
    int r, wf, wd;
    #12;
    chk("reset_outputs", {mem_req, mem_is_data, mem_we, ir_load, pc_load,
                          pc_sel, reg_we, halted, trapped}, 0);
    chk("reset_state", state, 0);
    chk("reset_retired", retired, 0);
    chk("reset_cause", trap_cause, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_no_run", state, 0);
    run = 1'b1;

    run_instr(OPI, 0, 0, 1'b0, 1'b1, 0);
    run_instr(LD, 0, 3, 1'b0, 1'b1, 0);
    run_instr(BR, 0, 0, 1'b1, 1'b1, 0);
    run_instr(BR, 0, 0, 1'b0, 1'b1, 0);
    run_instr(OPI, 3, 0, 1'b0, 1'b1, 0);
    run_instr(OPI, 99, 0, 1'b0, 1'b1, 2);
    run_instr(7'b0000000, 0, 0, 1'b0, 1'b1, 2);
    run_instr(SYS, 0, 0, 1'b0, 1'b1, 100);
    run_instr(ST, 0, 99, 1'b0, 1'b1, 2);
    run_instr(OPR, 1, 0, 1'b1, 1'b0, 3);

    for (int n = 0; n < 260; n++)
      run_instr(BR, 0, 0, 1'($urandom_range(0, 1)), 1'b1, 0);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) op = SYS;
      else if (r < 7) op = ill[$urandom_range(0, 3)];
      else op = legal[$urandom_range(0, 10)];
      wf = ($urandom_range(0, 29) == 0) ? TO + $urandom_range(0, 2)
                                        : $urandom_range(0, 3);
      wd = ($urandom_range(0, 19) == 0) ? TO + $urandom_range(0, 2)
                                        : $urandom_range(0, 3);
      run_instr(op, wf, wd, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0, $urandom_range(1, 4));
    end

    run_instr(OPI, 0, 0, 1'b0, 1'b1, 0);
    wait_state(3'd1, "rs_fetch");
    opcode = ST;
    take_branch = 1'b0;
    run = 1'b1;
    serve(0);
    wait_mem();
    chk("rs_retired_pre", retired, exp_ret);
    tick();
    tick();
    #1 reset = 1'b1;
    #1;
    chk("rs_mem_req", mem_req, 0);
    chk("rs_mem_we", mem_we, 0);
    chk("rs_state", state, 0);
    chk("rs_retired", retired, 0);
    sb.delete();
    exp_ret = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    tick();
    chk("rs_fetch_next", state, 1);
    run_instr(OPI, 0, 0, 1'b0, 1'b1, 0);

    repeat (3) tick();
    chk("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RV64 datapath. It steps each instruction through fetch, decode, execute, memory and write-back phases. It issues one-cycle enables to the PC, instruction register, register file and a shared instruction/data memory port, and runs a req/ready handshake with that memory, including a timeout. It sits beside the control unit: the control unit supplies per-opcode datapath selects, and this block supplies *when* each state element updates.

## Interface
- `TIMEOUT`, 16: max cycles `mem_req` may wait for `mem_ready`; 0 disables the timeout.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state cleared immediately.
- `run` in 1: permission to begin a new instruction.
- `opcode` in 7: `instruction[6:0]`, valid from DECODE onward (instruction register output).
- `take_branch` in 1: datapath branch/jump decision, sampled on the cycle `pc_load`=1.
- `mem_ready` in 1: memory completes the transfer on the edge where `mem_req`=1 and `mem_ready`=1.
- `mem_req` out 1: memory access request.
- `mem_is_data` out 1: 0 = instruction fetch, 1 = data access.
- `mem_we` out 1: data write (store); only ever 1 with `mem_is_data`=1.
- `ir_load` out 1: latch fetched word into the instruction register.
- `pc_load` out 1: update PC this edge.
- `pc_sel` out 1: 0 = PC+4, 1 = branch/jump target (equals `take_branch` when `pc_load`=1, else 0).
- `reg_we` out 1: register-file write enable.
- `state` out 3: current state encoding.
- `halted` out 1: state == HALT.
- `trapped` out 1: state == TRAP.
- `trap_cause` out 2: 0 none, 1 illegal opcode, 2 fetch timeout, 3 data timeout.
- `retired` out CNT_W: count of completed instructions.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7.
- IDLE: next state is FETCH if `run`, else IDLE.
- FETCH: `mem_req`=1, `mem_is_data`=0. On `mem_ready`, assert `ir_load` and go to DECODE.
- DECODE: classify `opcode`. Next state is EXEC for the legal classes: LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, OP-32 0111011, OP-IMM-32 0011011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - SYSTEM 1110011 goes to HALT.
  - Any other opcode goes to TRAP with cause 1.
- EXEC: LOAD and STORE go to MEM. BRANCH ends the instruction here. All other legal classes go to WB.
- MEM: `mem_req`=1, `mem_is_data`=1, `mem_we`=1 for STORE. On `mem_ready`, LOAD goes to WB and STORE ends the instruction.
- WB: `reg_we`=1 for one cycle, then the instruction ends.
- End of instruction (last cycle of BRANCH-EXEC, STORE-MEM-with-ready, or WB):
  - `pc_load`=1 and `pc_sel`=`take_branch`.
  - `retired` increments, wrapping modulo 2^CNT_W.
  - Next state is FETCH if `run`, else IDLE.
- HALT and TRAP are absorbing; only `reset` leaves them. All enables are 0 there.
- `run` is sampled only at IDLE and at instruction end. Deasserting `run` mid-instruction does not abort the instruction or an outstanding request.
- Timeout:
  - `wait_cnt` counts consecutive cycles with `mem_req`=1 and `mem_ready`=0, and clears on completion.
  - If `TIMEOUT`≠0 and `wait_cnt` == TIMEOUT-1 while `mem_ready`=0, next state is TRAP with cause 2 (FETCH) or 3 (MEM).
  - `mem_ready` arriving on the threshold cycle wins: normal completion, no trap.
- `trap_cause` is written only on entry to TRAP and cleared only by `reset`.
- `mem_ready` while `mem_req`=0 is ignored.

## Timing
- Reset (async): `state`=IDLE, `wait_cnt`=0, `retired`=0, `trap_cause`=0. Every output is 0.
- Enables are combinational from `state`, `opcode`, `mem_ready` and `take_branch`. State, counters and cause are registered.
- Latencies from FETCH entry with zero-wait memory:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- `ir_load` and `pc_load` are each high for exactly one cycle per instruction. `reg_we` is high for at most one.
- At most one `mem_req` transaction is outstanding. `mem_req`, `mem_is_data` and `mem_we` are stable until `mem_ready`.
- Reset asserted mid-handshake drops `mem_req` in the same cycle (asynchronous). No enable pulses follow reset.

## Test plan
- ADDI (opcode 0010011), `run`=1, `mem_ready`=1 always:
  - State sequence 1,2,3,5,1.
  - `reg_we` on cycle 4, `pc_load`=1 with `pc_sel`=0.
  - `retired` goes 0→1.
- LW with 3 wait states on the data access: MEM lasts 4 cycles with `mem_req`=1, `mem_is_data`=1, `mem_we`=0. WB follows, for 8 cycles total.
- Two BEQ instructions:
  - With `take_branch`=1, EXEC cycle shows `pc_load`=1, `pc_sel`=1 and no `reg_we`.
  - With `take_branch`=0, `pc_sel`=0.
- Timeout with `TIMEOUT`=4:
  - Fetch with `mem_ready` held 0: after 4 req cycles `state`=7 and `trap_cause`=2.
  - Rerun with `mem_ready`=1 on the 4th cycle: normal DECODE, no trap.
- Opcode 0000000 → TRAP with cause 1. Opcode 1110011 → HALT with `halted`=1, and the state holds for 100 cycles with `run`=1.
- Reset asserted during a STORE MEM wait:
  - `mem_req` and `mem_we` fall without waiting for `clk`.
  - `state`=0 and `retired`=0.
  - After release with `run`=1, FETCH begins on the next edge.
